sequencer_transport: RTL and testbench

Transport and edit scheduler for the step sequencer. Generates the tempo-driven step index and a one-cycle step strobe for the audio controller, with play, pause and stop. Serialises note edits from the button and rotary front end into the beat model through a single-entry buffer. Edits are never committed on the same cycle as a step advance. Sits between the input controllers and the `model` / `audio_controller` pair in `top`.

---
 rtl/sequencer_transport.sv | 86 ++++++++
 tb/tb_sequencer_transport.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sequencer_transport.sv
// sequencer_transport: tempo-driven step transport plus a single-entry edit buffer feeding the beat model.
// Optional SEQ_SWING_EN: even steps run period+period/8, odd steps period-period/8.
module sequencer_transport #(
  parameter int NUM_BEATS  = 16,
  parameter int BASE_TICKS = 1_500_000,
  parameter int TICK_STEP  = 75_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         play_toggle,
  input  logic                         stop,
  input  logic [3:0]                   tempo_idx,
  input  logic                         tempo_load,
  input  logic                         edit_valid,
  input  logic [7:0]                   edit_data,
  output logic                         edit_ready,
  output logic [7:0]                   data_in,
  output logic                         data_we,
  output logic [$clog2(NUM_BEATS)-1:0] beat_count,
  output logic                         beat_strobe,
  output logic                         playing
);
`ifdef SEQ_SWING_EN
  localparam int CW = $clog2(BASE_TICKS + (BASE_TICKS >> 3));
`else
  localparam int CW = $clog2(BASE_TICKS);
`endif
  localparam int PW = CW + 1;
  typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, last;
  logic [PW-1:0] period;
  logic [PW-1:0] per_tbl [16];
  logic [3:0] tempo_reg, tempo_pend, pend_nx;
  logic boundary, strobe_nx, commit, full;
  logic [7:0] buffer;
  for (genvar i = 0; i < 16; i++) begin : g_tbl
    assign per_tbl[i] = PW'(BASE_TICKS - i * TICK_STEP);
  end
  assign period = per_tbl[tempo_reg];
`ifdef SEQ_SWING_EN
  assign last = CW'(beat_count[0] ? period - (period >> 3) - 1 : period + (period >> 3) - 1);
`else
  assign last = CW'(period - 1);
`endif
  assign playing    = state == PLAYING;
  assign edit_ready = !full;
  always_comb begin
    boundary  = state == PLAYING && cnt == last;
    pend_nx   = tempo_load ? tempo_idx : tempo_pend;
    state_nx  = stop ? STOPPED : play_toggle ? (state == PLAYING ? PAUSED : PLAYING) : state;
    strobe_nx = !stop && (boundary || (state == STOPPED && play_toggle));
    // a buffered word that was not yet written retries every cycle that carries no step strobe
    commit    = full ? !data_we : edit_valid;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= STOPPED;
      cnt         <= '0;
      beat_count  <= '0;
      beat_strobe <= 1'b0;
      tempo_reg   <= '0;
      tempo_pend  <= '0;
      full        <= 1'b0;
      buffer      <= '0;
      data_in     <= '0;
      data_we     <= 1'b0;
    end else begin
      state       <= state_nx;
      beat_strobe <= strobe_nx;
      tempo_pend  <= pend_nx;
      if (state == STOPPED || boundary) tempo_reg <= pend_nx;
      if (stop || state == STOPPED) begin
        cnt        <= '0;
        beat_count <= '0;
      end else if (state == PLAYING) begin
        cnt <= boundary ? '0 : cnt + 1'b1;
        if (boundary) beat_count <= beat_count + 1'b1;
      end
      full    <= full ? !data_we : edit_valid;
      if (!full) buffer <= edit_data;
      data_we <= commit && !strobe_nx;
      if (commit && !strobe_nx) data_in <= full ? buffer : edit_data;
    end
  end
endmodule

// File: tb/tb_sequencer_transport.sv
// tb_sequencer_transport: directed scenarios plus random stimulus against a step-length reference model.
module tb_sequencer_transport;
  localparam int NB = 16;
  localparam int BT = 20;
  localparam int TS = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0, play_toggle = 1'b0, stop = 1'b0, tempo_load = 1'b0, edit_valid = 1'b0;
  logic [3:0] tempo_idx = 4'd0;
  logic [7:0] edit_data = 8'd0;
  logic edit_ready, data_we, beat_strobe, playing;
  logic [7:0] data_in;
  logic [3:0] beat_count;
  int n_cmp = 0, n_bad = 0, cyc = 0, n, k;
  int m_mode, m_rem, m_step, m_tempo, m_pend;
  bit m_strobe, m_held, m_we;
  logic [7:0] m_word, m_din;

  always #5 clk = ~clk;

  sequencer_transport #(.NUM_BEATS(NB), .BASE_TICKS(BT), .TICK_STEP(TS)) dut (
    .clk(clk), .rst_n(rst_n), .play_toggle(play_toggle), .stop(stop),
    .tempo_idx(tempo_idx), .tempo_load(tempo_load), .edit_valid(edit_valid),
    .edit_data(edit_data), .edit_ready(edit_ready), .data_in(data_in),
    .data_we(data_we), .beat_count(beat_count), .beat_strobe(beat_strobe),
    .playing(playing)
  );

  function automatic int step_len(input int step, input int tempo);
    int p, sw;
    p  = BT - tempo * TS;
    sw = 0;
`ifdef SEQ_SWING_EN
    sw = p / 8;
`endif
    return (step % 2 == 0) ? p + sw : p - sw;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mode 0 stopped, 1 playing, 2 paused; m_rem counts playing cycles left in the current step
  task automatic model_step();
    int nx_pend;
    bit ns;
    if (!rst_n) begin
      m_mode = 0; m_rem = 0; m_step = 0; m_tempo = 0; m_pend = 0;
      m_strobe = 0; m_held = 0; m_we = 0; m_word = 0; m_din = 0;
      return;
    end
    nx_pend = tempo_load ? int'(tempo_idx) : m_pend;
    ns = 0;
    case (m_mode)
      0: begin
        m_tempo = nx_pend;
        if (play_toggle) begin
          m_mode = 1; m_step = 0; m_rem = step_len(0, m_tempo); ns = 1;
        end
      end
      1: begin
        m_rem--;
        if (m_rem == 0) begin
          m_step = (m_step + 1) % NB; m_tempo = nx_pend; m_rem = step_len(m_step, m_tempo); ns = 1;
        end
        if (play_toggle) m_mode = 2;
      end
      default: if (play_toggle) m_mode = 1;
    endcase
    if (stop) begin
      m_mode = 0; m_step = 0; ns = 0;
    end
    m_pend = nx_pend;
    m_strobe = ns;
    if (m_held && m_we) m_held = 0;
    else if (!m_held && edit_valid) begin
      m_held = 1; m_word = edit_data;
    end
    m_we = m_held && !ns;
    if (m_we) m_din = m_word;
  endtask

  task automatic tick();
    bit acc;
    acc = rst_n && edit_valid && edit_ready;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check("beat_count", beat_count, m_step);
    check("beat_strobe", beat_strobe, m_strobe);
    check("playing", playing, m_mode == 1);
    check("edit_ready", edit_ready, !m_held);
    check("data_we", data_we, m_we);
    check("data_in", data_in, m_din);
    play_toggle = 0; stop = 0; tempo_load = 0;
    if (acc) edit_valid = 0;
  endtask

  task automatic wait_strobe(input int budget, output int n_cyc);
    n_cyc = 0;
    do begin
      tick();
      n_cyc++;
    end while (!beat_strobe && n_cyc < budget);
    check("strobe_seen", beat_strobe, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_beat_count", beat_count, 0);
    check("rst_playing", playing, 0);
    check("rst_edit_ready", edit_ready, 1);
    check("rst_data_in", data_in, 0);
    rst_n = 1;
    repeat (6) tick();
    play_toggle = 1; tick();
    check("start_strobe", beat_strobe, 1);
    check("start_count", beat_count, 0);
    check("start_playing", playing, 1);
    wait_strobe(40, n);
    check("first_spacing", n, step_len(0, 0));
    check("first_count", beat_count, 1);
    repeat (15) wait_strobe(40, n);
    check("wrap_count", beat_count, 0);
    repeat (3) wait_strobe(40, n);
    repeat (7) tick();
    play_toggle = 1; tick();
    check("pause_playing", playing, 0);
    k = 0;
    repeat (50) begin
      tick();
      k += int'(beat_strobe);
    end
    check("pause_strobes", k, 0);
    play_toggle = 1; tick();
    check("resume_no_strobe", beat_strobe, 0);
    check("resume_playing", playing, 1);
    wait_strobe(40, n);
    check("resume_gap", n + 1, step_len(3, 0) - 7);
    check("resume_count", beat_count, 4);
    repeat (5) wait_strobe(40, n);
    repeat (4) tick();
    stop = 1; play_toggle = 1; tick();
    check("stop_playing", playing, 0);
    check("stop_count", beat_count, 0);
    check("stop_strobe", beat_strobe, 0);
    repeat (2) tick();
    play_toggle = 1; tick();
    repeat (5) tick();
    tempo_idx = 4'd4; tempo_load = 1; tick();
    wait_strobe(40, n);
    check("tempo_cur_step", n + 6, step_len(0, 0));
    wait_strobe(40, n);
    check("tempo_next_step", n, step_len(1, 4));
    wait_strobe(40, n);
    check("tempo_step2", n, step_len(2, 4));
    repeat (step_len(3, 4) - 1) tick();
    edit_valid = 1; edit_data = 8'h35; tick();
    check("col_strobe", beat_strobe, 1);
    check("col_we_deferred", data_we, 0);
    check("col_ready", edit_ready, 0);
    edit_valid = 1; edit_data = 8'ha7; tick();
    check("col_we", data_we, 1);
    check("col_data", data_in, 8'h35);
    check("col_ready2", edit_ready, 0);
    tick();
    check("col_ready3", edit_ready, 1);
    check("col_we_off", data_we, 0);
    tick();
    check("second_we", data_we, 1);
    check("second_data", data_in, 8'ha7);
`ifdef SEQ_SWING_EN
    rst_n = 0; tick(); rst_n = 1;
    play_toggle = 1; tick();
    wait_strobe(40, n);
    check("swing_even", n, 22);
    wait_strobe(40, n);
    check("swing_odd", n, 18);
`endif
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 499) != 0;
      play_toggle = $urandom_range(0, 39) == 0;
      stop = $urandom_range(0, 149) == 0;
      tempo_load = $urandom_range(0, 49) == 0;
      tempo_idx = 4'($urandom);
      if (!edit_valid && $urandom_range(0, 3) == 0) begin
        edit_valid = 1;
        edit_data = 8'($urandom);
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
